// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM command arbiter: FSM state encoding
// and requester port indices.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and flags expiry
// on the cycle the count would reach TIMEOUT.
module sdram_arb_watchdog #(
    parameter int TIMEOUT       = 1024,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    // Expiry is combinational so the owner can abort on the same edge the limit is hit.
    assign o_expire = i_enable && !i_clear && (r_count == TIMEOUT_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_enable || i_clear || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin scheduler sharing one SDRAM controller command interface between
// two requesters, with a per-grant word count and a beat watchdog.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 22,
    parameter int COUNT_WIDTH   = 8,
    parameter int TIMEOUT       = 1024,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic                   a_write,
    input  logic [ADDR_WIDTH-1:0]  a_address,
    input  logic [COUNT_WIDTH-1:0] a_count,
    output logic                   a_grant,
    output logic                   a_done,
    input  logic                   b_req,
    input  logic                   b_write,
    input  logic [ADDR_WIDTH-1:0]  b_address,
    input  logic [COUNT_WIDTH-1:0] b_count,
    output logic                   b_grant,
    output logic                   b_done,
    input  logic                   sdram_ready,
    input  logic                   beat,
    output logic                   write_en,
    output logic                   read_en,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   owner,
    output logic                   busy,
    output logic                   timeout_err
);

    state_t                 r_state,     w_state_nxt;
    logic                   r_ptr,       w_ptr_nxt;
    logic                   r_owner,     w_owner_nxt;
    logic                   r_write,     w_write_nxt;
    logic [ADDR_WIDTH-1:0]  r_address,   w_address_nxt;
    logic [COUNT_WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_wen,       w_wen_nxt;
    logic                   r_ren,       w_ren_nxt;
    logic                   r_done_a,    w_done_a_nxt;
    logic                   r_done_b,    w_done_b_nxt;
    logic                   r_tmo,       w_tmo_nxt;

    logic                   w_sel;
    logic                   w_sel_write;
    logic [ADDR_WIDTH-1:0]  w_sel_address;
    logic [COUNT_WIDTH-1:0] w_sel_count;
    logic                   w_expire;

    // Contention goes to the pointer; a lone requester always wins.
    assign w_sel         = (a_req && b_req) ? r_ptr : (b_req ? PORT_B : PORT_A);
    assign w_sel_write   = (w_sel == PORT_B) ? b_write   : a_write;
    assign w_sel_address = (w_sel == PORT_B) ? b_address : a_address;
    assign w_sel_count   = (w_sel == PORT_B) ? b_count   : a_count;

    sdram_arb_watchdog #(
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_enable (r_state == ACTIVE),
        .i_clear  (beat),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= PORT_A;
            r_owner     <= PORT_A;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_write     <= w_write_nxt;
            r_address   <= w_address_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= w_busy_nxt;
            r_wen       <= w_wen_nxt;
            r_ren       <= w_ren_nxt;
            r_done_a    <= w_done_a_nxt;
            r_done_b    <= w_done_b_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_write_nxt     = r_write;
        w_address_nxt   = r_address;
        w_remaining_nxt = r_remaining;
        w_busy_nxt      = r_busy;
        w_wen_nxt       = r_wen;
        w_ren_nxt       = r_ren;
        w_done_a_nxt    = 1'b0;
        w_done_b_nxt    = 1'b0;
        w_tmo_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (sdram_ready && (a_req || b_req)) begin
                    w_owner_nxt     = w_sel;
                    w_write_nxt     = w_sel_write;
                    w_address_nxt   = w_sel_address;
                    w_remaining_nxt = w_sel_count;
                    w_busy_nxt      = 1'b1;
                    // A zero-length request is acknowledged without touching the controller.
                    if (w_sel_count == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ACTIVE;
                        w_wen_nxt   = w_sel_write;
                        w_ren_nxt   = !w_sel_write;
                    end
                end
            end
            ACTIVE: begin
                if (beat) begin
                    w_remaining_nxt = r_remaining - COUNT_WIDTH'(1);
                    if (r_remaining == COUNT_WIDTH'(1)) begin
                        w_wen_nxt   = 1'b0;
                        w_ren_nxt   = 1'b0;
                        w_state_nxt = DRAIN;
                    end
                end else if (w_expire) begin
                    w_tmo_nxt   = 1'b1;
                    w_wen_nxt   = 1'b0;
                    w_ren_nxt   = 1'b0;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (sdram_ready) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy_nxt   = 1'b0;
                w_done_a_nxt = (r_owner == PORT_A);
                w_done_b_nxt = (r_owner == PORT_B);
                w_ptr_nxt    = ~r_owner;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign a_grant     = r_busy && (r_owner == PORT_A);
    assign b_grant     = r_busy && (r_owner == PORT_B);
    assign a_done      = r_done_a;
    assign b_done      = r_done_b;
    assign write_en    = r_wen;
    assign read_en     = r_ren;
    assign address     = r_address;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign timeout_err = r_tmo;

endmodule
